alu_issue_sched: RTL and testbench
==================================

Name: alu_issue_sched

Overview:
- Issue scheduler for the integer ALU pool in the OoO core. Sits between the reservation station / issue queue and the ALU instances.
- Each cycle it picks ready instructions round-robin and binds each one to a free ALU.
- Drives the per-ALU one-hot select (alu_number) and tells each ALU which requester's operands to take.
- Tracks multi-cycle occupancy per ALU so a busy unit is never issued to.

Parameters:
- NUM_REQ, 4, number of issue-queue requester slots presented each cycle.
- NUM_FU, 3, number of ALUs scheduled; matches alu_number width.
- MULTI_LAT, 3, occupancy in cycles of an op flagged multi-cycle; must be >= 2.
- IDX_W, $clog2(NUM_REQ), localparam; width of one requester index.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rstn  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- flush  in  1  pipeline flush; suppresses new grants this cycle.
- req_valid  in  NUM_REQ  requester i holds an instruction ready to issue.
- req_multi  in  NUM_REQ  requester i's op occupies its ALU for MULTI_LAT cycles.
- fu_ready  in  NUM_FU  FU_ready from each ALU.
- req_grant  out  NUM_REQ  combinational; requester i issued this cycle and must dequeue at the edge.
- alu_number  out  NUM_FU  registered; bit k = ALU k executes an op this cycle.
- issue_idx  out  NUM_FU*IDX_W  registered; field k = requester index bound to ALU k.
- issue_multi  out  NUM_FU  registered; bit k = op on ALU k is multi-cycle.
- busy_vec  out  NUM_FU  registered; bit k = ALU k is occupied (busy_cnt[k] != 0).

Behaviour:
- Reset (rstn=0 at an edge):
  - Registered outputs go to 0: alu_number, issue_idx, issue_multi, busy_vec.
  - All busy_cnt go to 0 and rr_ptr goes to 0.
  - req_grant is forced to 0 combinationally while rstn=0.
  - Reset has priority over flush and over requests; reset mid multi-cycle op clears its busy count.
- Free test: ALU k is free iff busy_cnt[k]==0 and fu_ready[k]==1.
- Arbitration (combinational):
  - Scan requesters in order rr_ptr, rr_ptr+1, … (mod NUM_REQ).
  - Each valid requester takes the lowest-index free ALU not already taken this cycle.
  - Stop when all free ALUs are taken. At most min(#valid, #free) grants per cycle.
- Issue latency:
  - Grant in cycle t gives alu_number[k]=1 in cycle t+1, with issue_idx field k = granted index and issue_multi[k] = req_multi of that requester.
  - An ALU not granted in cycle t shows alu_number[k]=0 in t+1.
- Occupancy counter per ALU:
  - On grant, busy_cnt[k] loads 0 for a single-cycle op or MULTI_LAT-1 for a multi-cycle op.
  - Otherwise a nonzero busy_cnt decrements by 1 each cycle.
  - Net effect: a single-cycle op allows back-to-back issue to the same ALU every cycle; a multi-cycle op blocks that ALU for the MULTI_LAT-1 cycles after its grant cycle.
- rr_ptr:
  - If any grant occurs, rr_ptr becomes (last granted index in scan order + 1) mod NUM_REQ.
  - If no grant occurs, rr_ptr holds.
  - Wrap-around is modulo NUM_REQ.
- Flush:
  - req_grant=0 in that cycle; alu_number is 0 in the following cycle.
  - rr_ptr holds.
  - busy_cnt continues counting down, since an in-flight ALU op still completes.
- Degenerate cycles: no valid requester, or no free ALU, produces no grants; registered alu_number=0 next cycle.
- The grant set is a pure function of inputs and current state; there are no combinational paths from req_grant back into the scheduler.

Optional Feature:
- Macro: ALU_SCHED_PERF_EN.
- Defined: adds two outputs, perf_issued (32-bit count of total grants, adding popcount(req_grant) per cycle) and perf_stall (32-bit count of cycles with |req_valid, !flush and req_grant==0).
  - Both clear on reset and wrap at 2^32.
- Undefined: the two ports and counters do not exist; all other behaviour is identical.

Test Plan:
Defaults NUM_REQ=4, NUM_FU=3, MULTI_LAT=3, fu_ready=3'b111 unless stated.
1. Reset: rstn=0 for 2 cycles with req_valid=4'hF -> req_grant=0 and alu_number=0 throughout. First cycle after release: req_grant=4'b0111. Next cycle: alu_number=3'b111, issue_idx = {2,1,0}.
2. Round-robin: continue with req_valid=4'hF, all single-cycle -> second grant cycle req_grant=4'b1011 (req3→ALU0, req0→ALU1, req1→ALU2). Third grant cycle: req_grant=4'b1101, starting from rr_ptr=2.
3. Multi-cycle: from idle, req_valid=4'b0001, req_multi=4'b0001 in cycle t -> ALU0 granted, busy_vec=3'b001 in t+1 and t+2, 3'b000 in t+3. A request raised in t+1 is bound to ALU1.
4. Unit not ready: fu_ready=3'b101, req_valid=4'hF -> exactly 2 grants, bound to ALU0 and ALU2; alu_number next cycle = 3'b101.
5. Flush: flush=1 with req_valid=4'hF while ALU1 has busy_cnt=2 -> req_grant=0, alu_number=0 next cycle, rr_ptr unchanged. ALU1 busy_cnt reaches 0 two cycles later.
6. Perf (ALU_SCHED_PERF_EN defined): run scenarios 1–2 then 3 stall cycles with fu_ready=0 -> perf_issued=9, perf_stall=3.

Source files
------------

// File: rtl/alu_issue_sched.sv
// Round-robin issue scheduler binding ready requesters to free ALUs, with per-ALU occupancy tracking.
// Optional perf counters (perf_issued, perf_stall) are built when ALU_SCHED_PERF_EN is defined.
module alu_issue_sched #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_FU    = 3,
    parameter int MULTI_LAT = 3,
    localparam int IDX_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    flush,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ-1:0]      req_multi,
    input  logic [NUM_FU-1:0]       fu_ready,
    output logic [NUM_REQ-1:0]      req_grant,
    output logic [NUM_FU-1:0]       alu_number,
    output logic [NUM_FU*IDX_W-1:0] issue_idx,
    output logic [NUM_FU-1:0]       issue_multi,
`ifdef ALU_SCHED_PERF_EN
    output logic [31:0]             perf_issued,
    output logic [31:0]             perf_stall,
`endif
    output logic [NUM_FU-1:0]       busy_vec
);

    localparam int CNT_W = $clog2(MULTI_LAT);
    localparam logic [CNT_W-1:0] MULTI_LOAD = CNT_W'(MULTI_LAT - 1);

    logic [IDX_W-1:0] rr_ptr;
    logic [CNT_W-1:0] busy_cnt [NUM_FU];
    logic [CNT_W-1:0] cnt_nxt  [NUM_FU];

    logic [NUM_FU-1:0] fu_free;
    logic [NUM_FU-1:0] fu_taken;
    logic [NUM_FU-1:0] bind_multi;
    logic [IDX_W-1:0]  bind_idx [NUM_FU];
    logic [IDX_W-1:0]  ptr_nxt;
    logic              any_grant;
    logic              placed;
    int                pos;

    always_comb begin
        for (int k = 0; k < NUM_FU; k++) begin
            fu_free[k] = (busy_cnt[k] == '0) && fu_ready[k];
        end
    end

    // Arbitration: scan from rr_ptr, each valid requester takes the lowest free untaken ALU
    always_comb begin
        req_grant  = '0;
        fu_taken   = '0;
        bind_multi = '0;
        ptr_nxt    = rr_ptr;
        any_grant  = 1'b0;
        placed     = 1'b0;
        pos        = 0;
        for (int k = 0; k < NUM_FU; k++) begin
            bind_idx[k] = '0;
        end
        for (int s = 0; s < NUM_REQ; s++) begin
            pos = int'(rr_ptr) + s;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            placed = 1'b0;
            if (rstn && !flush && req_valid[pos]) begin
                for (int k = 0; k < NUM_FU; k++) begin
                    if (!placed && fu_free[k] && !fu_taken[k]) begin
                        fu_taken[k]    = 1'b1;
                        bind_idx[k]    = IDX_W'(pos);
                        bind_multi[k]  = req_multi[pos];
                        req_grant[pos] = 1'b1;
                        placed         = 1'b1;
                    end
                end
            end
            if (placed) begin
                any_grant = 1'b1;
                ptr_nxt   = (pos == NUM_REQ - 1) ? '0 : IDX_W'(pos + 1);
            end
        end
    end

    // Occupancy: load on grant, otherwise count down to zero (flush does not stop this)
    always_comb begin
        for (int k = 0; k < NUM_FU; k++) begin
            cnt_nxt[k] = busy_cnt[k];
            if (fu_taken[k]) begin
                cnt_nxt[k] = bind_multi[k] ? MULTI_LOAD : '0;
            end else if (busy_cnt[k] != '0) begin
                cnt_nxt[k] = busy_cnt[k] - 1'b1;
            end
        end
    end

    // Issue stage registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr      <= '0;
            alu_number  <= '0;
            issue_idx   <= '0;
            issue_multi <= '0;
            busy_vec    <= '0;
            for (int k = 0; k < NUM_FU; k++) begin
                busy_cnt[k] <= '0;
            end
        end else begin
            if (any_grant) begin
                rr_ptr <= ptr_nxt;
            end
            alu_number  <= fu_taken;
            issue_multi <= bind_multi;
            for (int k = 0; k < NUM_FU; k++) begin
                busy_cnt[k]                 <= cnt_nxt[k];
                busy_vec[k]                 <= (cnt_nxt[k] != '0);
                issue_idx[k*IDX_W +: IDX_W] <= bind_idx[k];
            end
        end
    end

`ifdef ALU_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            perf_issued <= perf_issued + 32'($countones(req_grant));
            if ((|req_valid) && !flush && (req_grant == '0)) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_sched.sv
// Directed bench for alu_issue_sched: reset, round-robin, multi-cycle occupancy, not-ready units, flush.
module tb_alu_issue_sched;

    logic       clk = 1'b0;
    logic       rstn;
    logic       flush;
    logic [3:0] req_valid;
    logic [3:0] req_multi;
    logic [2:0] fu_ready;
    logic [3:0] req_grant;
    logic [2:0] alu_number;
    logic [5:0] issue_idx;
    logic [2:0] issue_multi;
    logic [2:0] busy_vec;
`ifdef ALU_SCHED_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_stall;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_issue_sched #(.NUM_REQ(4), .NUM_FU(3), .MULTI_LAT(3)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_multi   (req_multi),
        .fu_ready    (fu_ready),
        .req_grant   (req_grant),
        .alu_number  (alu_number),
        .issue_idx   (issue_idx),
        .issue_multi (issue_multi),
`ifdef ALU_SCHED_PERF_EN
        .perf_issued (perf_issued),
        .perf_stall  (perf_stall),
`endif
        .busy_vec    (busy_vec)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; req_valid = 4'hF; req_multi = 4'h0; fu_ready = 3'b111;

        // Reset held for two edges with requests pending
        tick();
        chk("rst_grant0", 32'(req_grant), 32'h0);
        chk("rst_alu0", 32'(alu_number), 32'h0);
        chk("rst_idx", 32'(issue_idx), 32'h0);
        chk("rst_multi", 32'(issue_multi), 32'h0);
        chk("rst_busy", 32'(busy_vec), 32'h0);
        tick();
        chk("rst_grant1", 32'(req_grant), 32'h0);
        chk("rst_alu1", 32'(alu_number), 32'h0);

        // Round-robin with all single-cycle ops
        rstn = 1'b1;
        #1;
        chk("rr1_grant", 32'(req_grant), 32'b0111);
        tick();
        chk("rr1_alu", 32'(alu_number), 32'b111);
        chk("rr1_idx", 32'(issue_idx), 32'h24);
        chk("rr2_grant", 32'(req_grant), 32'b1011);
        tick();
        chk("rr2_alu", 32'(alu_number), 32'b111);
        chk("rr2_idx", 32'(issue_idx), 32'h13);
        chk("rr3_grant", 32'(req_grant), 32'b1101);
        tick();
        chk("rr3_alu", 32'(alu_number), 32'b111);
        chk("rr3_idx", 32'(issue_idx), 32'h0E);

        // Three stall cycles: no ALU ready
        fu_ready = 3'b000;
        #1;
        chk("stall_grant", 32'(req_grant), 32'h0);
        tick();
        chk("stall_alu", 32'(alu_number), 32'h0);
        tick();
        tick();
`ifdef ALU_SCHED_PERF_EN
        chk("perf_issued", perf_issued, 32'd9);
        chk("perf_stall", perf_stall, 32'd3);
`endif

        // Multi-cycle op on ALU0 (rr_ptr is 1 here)
        req_valid = 4'b0000; fu_ready = 3'b111;
        tick();
        chk("idle_alu", 32'(alu_number), 32'h0);
        req_valid = 4'b0001; req_multi = 4'b0001;
        #1;
        chk("mc_grant", 32'(req_grant), 32'b0001);
        tick();
        chk("mc_busy_t1", 32'(busy_vec), 32'b001);
        chk("mc_alu_t1", 32'(alu_number), 32'b001);
        chk("mc_imulti_t1", 32'(issue_multi), 32'b001);
        chk("mc_idx0_t1", 32'(issue_idx[1:0]), 32'd0);
        req_valid = 4'b0010; req_multi = 4'b0000;
        #1;
        chk("mc_grant_t1", 32'(req_grant), 32'b0010);
        tick();
        chk("mc_busy_t2", 32'(busy_vec), 32'b001);
        chk("mc_alu_t2", 32'(alu_number), 32'b010);
        chk("mc_idx1_t2", 32'(issue_idx[3:2]), 32'd1);
        chk("mc_imulti_t2", 32'(issue_multi), 32'b000);
        req_valid = 4'b0000;
        tick();
        chk("mc_busy_t3", 32'(busy_vec), 32'b000);
        chk("mc_alu_t3", 32'(alu_number), 32'h0);

        // ALU1 not ready (rr_ptr is 2)
        fu_ready = 3'b101; req_valid = 4'hF;
        #1;
        chk("nr_grant", 32'(req_grant), 32'b1100);
        tick();
        chk("nr_alu", 32'(alu_number), 32'b101);
        chk("nr_idx0", 32'(issue_idx[1:0]), 32'd2);
        chk("nr_idx2", 32'(issue_idx[5:4]), 32'd3);

        // Put a multi-cycle op on ALU1 (rr_ptr is 0), then flush
        fu_ready = 3'b110; req_valid = 4'b0001; req_multi = 4'b0001;
        #1;
        chk("fl_setup_grant", 32'(req_grant), 32'b0001);
        tick();
        chk("fl_setup_alu", 32'(alu_number), 32'b010);
        chk("fl_setup_busy", 32'(busy_vec), 32'b010);
        flush = 1'b1; fu_ready = 3'b111; req_valid = 4'hF; req_multi = 4'h0;
        #1;
        chk("fl_grant", 32'(req_grant), 32'h0);
        tick();
        chk("fl_alu", 32'(alu_number), 32'h0);
        chk("fl_busy", 32'(busy_vec), 32'b010);
        flush = 1'b0;
        #1;
        chk("post_fl_grant", 32'(req_grant), 32'b0110);
        tick();
        chk("post_fl_busy", 32'(busy_vec), 32'b000);
        chk("post_fl_alu", 32'(alu_number), 32'b101);
        chk("post_fl_idx0", 32'(issue_idx[1:0]), 32'd1);
        chk("post_fl_idx2", 32'(issue_idx[5:4]), 32'd2);

        // Reset in the middle of a multi-cycle op (rr_ptr is 3)
        req_valid = 4'b1000; req_multi = 4'b1000;
        #1;
        chk("mr_grant", 32'(req_grant), 32'b1000);
        tick();
        chk("mr_busy", 32'(busy_vec), 32'b001);
        rstn = 1'b0; req_valid = 4'b0000;
        tick();
        chk("mr_rst_busy", 32'(busy_vec), 32'b000);
        chk("mr_rst_alu", 32'(alu_number), 32'b000);
        rstn = 1'b1; req_valid = 4'b0001; req_multi = 4'b0000;
        #1;
        chk("mr_ptr_grant", 32'(req_grant), 32'b0001);
        tick();
        chk("mr_ptr_alu", 32'(alu_number), 32'b001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
